binbcd_seq: RTL and testbench
=============================

Name: binbcd_seq

Overview:
Sequential binary-to-BCD converter using iterative shift-add-3 (double dabble), one bit per clock. It is the upstream stage of the x7segb 7-segment display driver and replaces the combinational binbcd8 converter when wider inputs make a one-cycle array too large. A start/busy/done handshake launches a conversion. The BCD result is held in an output register so the display never shows intermediate values.

Parameters:
N, 8, binary input width in bits (legal range 4..16)
D, 3, number of BCD output digits; must satisfy 10^D > 2^N - 1 (elaboration-time check, fatal on violation)

Ports:
clk  input  1  system clock, rising-edge active
clr_n  input  1  asynchronous, active-low reset
start  input  1  request conversion of din; sampled only in IDLE
din  input  N  binary operand; captured on the accepting edge only
busy  output  1  high while a conversion is in progress (state != IDLE)
done  output  1  one-cycle pulse; bcd holds the new result from this cycle onward
bcd  output  4*D  packed BCD result, digit 0 in bits [3:0]; top level zero-pads to 16 bits for x7segb

Behaviour:
- Reset (clr_n low, asynchronous): state=IDLE, bcd=0, done=0, busy=0, internal shift/scratch/count registers=0. Release is synchronous to the next clk edge.
- States: IDLE, CONV, DONE. Encoding is binary with 2 bits.
- IDLE: on an edge with start=1:
  - load bin_sr<=din, scratch<=0, cnt<=N
  - go to CONV
  - with start=0, remain in IDLE
- CONV: each edge performs one iteration:
  - every 4-bit digit of scratch that is >=5 gets +3 (all digits in parallel)
  - then {scratch, bin_sr} shifts left by 1; the MSB of bin_sr enters scratch bit 0
  - cnt<=cnt-1
  - the edge on which cnt==1 also moves the state to DONE, so exactly N iterations run
- DONE: on the next edge, bcd<=scratch, done<=1, state<=IDLE.
- done is registered and high for exactly one cycle. It is low in every other cycle.
- Latency: start is sampled at edge E0. Iterations run at E1..EN. bcd and done update at E(N+1). Default N=8 gives 9 cycles from the accepting edge to done.
- busy is combinational from the state register: high in CONV and DONE, low in IDLE. During the done cycle busy=0.
- start while busy: ignored. It is not queued, and din is not sampled.
- start high in the done cycle: accepted, so back-to-back conversions run with no dead cycle. bcd keeps the previous result until the next done.
- start held high continuously: a new conversion begins every N+2 cycles.
- bcd changes only at DONE->IDLE edges or on reset. It never shows partial values.
- Digit adjust arithmetic: 4-bit unsigned add with no carry out of the digit. A digit is <=9 after every shift by construction, so post-adjust values are <=12.
- Reset mid-conversion: conversion is aborted, all outputs return to 0, and no done is issued.
- din=0 gives bcd=0. Maximum din (2^N-1) produces correct digits given the D constraint. Unused high digits read 0.

Decomposition:
- Shared package/header binbcd_pkg holds:
  - state localparams ST_IDLE=2'd0, ST_CONV=2'd1, ST_DONE=2'd2
  - the count width function clog2(N+1)
- One natural sub-module: add3 (combinational, 4-bit in/out; output = in>=5 ? in+3 : in). It is instantiated D times via generate.
- The FSM, counter and shift registers stay in binbcd_seq.

Test Plan:
- Reset then din=8'd255, 1-cycle start -> busy high for 9 cycles; done pulse 9 cycles after the start edge; bcd=12'h255; done low afterward.
- din=0, 99, 100, 200 in sequence -> bcd=12'h000, 12'h099, 12'h100, 12'h200, each with exactly one done pulse.
- start held high with din=37 then 184 changed at each done -> conversions every 10 cycles; bcd=12'h037 then 12'h184; bcd stable between done pulses.
- start pulsed with din=12, then start=1 with din=250 at cycle 4 while busy -> ignored; result bcd=12'h012; only one done.
- clr_n low at cycle 5 of a din=255 conversion -> bcd=0, busy=0, done=0 immediately; no done after release; a fresh start with din=7 yields 12'h007.
- Exhaustive sweep of din 0..255 (N=8, D=3) and sampled values for N=13, D=4 (8191 -> 16'h8191) -> every result matches a reference model.

Source files
------------

// File: rtl/binbcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package binbcd_pkg;

  // 2-bit binary state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Smallest w such that 2^w >= v; used as clog2(N+1) for the iteration counter
  function automatic int clog2(input int v);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < v) w = w + 1;
    end
    return w;
  endfunction

  // 10^d, used to confirm D digits can hold 2^N - 1
  function automatic int pow10(input int d);
    int r;
    r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
// Inputs are at most 9, so the result is at most 12 and never carries out.
module add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Conditional +3 ahead of the shift
  always_comb begin
    dout = (din >= 4'd5) ? (din + 4'd3) : din;
  end

endmodule

// File: rtl/binbcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble iteration per clock.
// The result register only updates when a conversion finishes, so downstream
// display logic never sees partial digits.
//
// state   | meaning
// IDLE    | waiting for start; done cycle also lives here
// CONV    | shifting one binary bit per clock, N iterations
// DONE    | copy scratch into the result register, pulse done
module binbcd_seq #(
  parameter int N = 8,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           start,
  input  logic [N-1:0]   din,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd
);
  import binbcd_pkg::*;

  localparam int CW = clog2(N + 1);
  localparam int BW = 4 * D;

  // Reject widths the digit count cannot represent
  if (N < 4 || N > 16 || pow10(D) <= ((1 << N) - 1)) begin : g_param_err
    $fatal(1, "binbcd_seq: illegal parameters N=%0d D=%0d", N, D);
  end

  logic [1:0]    state_q,   state_d;
  logic [N-1:0]  bin_sr_q,  bin_sr_d;
  logic [BW-1:0] scratch_q, scratch_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [BW-1:0] bcd_q,     bcd_d;
  logic          done_q,    done_d;

  logic [BW-1:0] adj;
  logic          unused_adj_msb;

  for (genvar g = 0; g < D; g++) begin : g_add3
    add3 u_add3 (
      .din  (scratch_q[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // Top bit of the adjusted scratch is shifted out; it is always 0 given the D check
  assign unused_adj_msb = adj[BW-1];

  // State and datapath registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= ST_IDLE;
      bin_sr_q  <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_sr_q  <= bin_sr_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

  // Next-state: the iteration with cnt==1 is the last one
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CONV;
      ST_CONV: if (cnt_q == CW'(1)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: load on accept, adjust-then-shift while converting, publish at the end
  always_comb begin
    bin_sr_d  = bin_sr_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_sr_d  = din;
          scratch_d = '0;
          cnt_d     = CW'(N);
        end
      end
      ST_CONV: begin
        scratch_d = {adj[BW-2:0], bin_sr_q[N-1]};
        bin_sr_d  = {bin_sr_q[N-2:0], 1'b0};
        cnt_d     = cnt_q - CW'(1);
      end
      ST_DONE: begin
        bcd_d  = scratch_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs: busy decodes the state, done and bcd come straight from flops
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = done_q;
    bcd  = bcd_q;
  end

endmodule

// File: tb/tb_binbcd_seq.sv
module tb_binbcd_seq;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        start;
  logic [7:0]  din;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  logic        start13;
  logic [12:0] din13;
  logic        busy13;
  logic        done13;
  logic [15:0] bcd13;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] sb[$];

  binbcd_seq #(.N(8), .D(3)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .din(din),
    .busy(busy), .done(done), .bcd(bcd)
  );

  binbcd_seq #(.N(13), .D(4)) dut13 (
    .clk(clk), .clr_n(clr_n), .start(start13), .din(din13),
    .busy(busy13), .done(done13), .bcd(bcd13)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [15:0] obs);
    logic [15:0] exp;
    chk({tag, " queue"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      chk({tag, " bcd"}, 32'(obs), 32'(exp));
    end
  endtask

  task automatic run8(input int v, input string tag);
    int lat, bcnt;
    @(negedge clk); start = 1'b1; din = 8'(v); sb.push_back(ref_bcd(v));
    @(negedge clk); start = 1'b0;
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk); lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd9);
    chk({tag, " busy cycles"}, 32'(bcnt), 32'd9);
    chk({tag, " busy in done cycle"}, 32'(busy), 32'd0);
    pop_check(tag, {4'h0, bcd});
    @(negedge clk);
    chk({tag, " done single"}, 32'(done), 32'd0);
  endtask

  task automatic run13(input int v, input string tag);
    int lat;
    @(negedge clk); start13 = 1'b1; din13 = 13'(v); sb.push_back(ref_bcd(v));
    @(negedge clk); start13 = 1'b0;
    lat = 0;
    while (done13 !== 1'b1 && lat < 60) begin
      @(negedge clk); lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd14);
    pop_check(tag, bcd13);
    @(negedge clk);
    chk({tag, " done single"}, 32'(done13), 32'd0);
  endtask

  initial begin
    int gap, stable, ndone, lat;
    clr_n = 1'b0; start = 1'b0; din = '0; start13 = 1'b0; din13 = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset bcd", 32'(bcd), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset bcd13", 32'(bcd13), 32'h0);
    clr_n = 1'b1;

    // max value and a set of directed values
    run8(255, "d255");
    run8(0,   "d0");
    run8(99,  "d99");
    run8(100, "d100");
    run8(200, "d200");

    // start held high, din changed at each done
    @(negedge clk); start = 1'b1; din = 8'd37; sb.push_back(ref_bcd(37));
    @(negedge clk);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    chk("held first latency", 32'(lat), 32'd9);
    pop_check("held 37", {4'h0, bcd});
    din = 8'd184; sb.push_back(ref_bcd(184));
    gap = 1; stable = 1;
    @(negedge clk);
    while (done !== 1'b1 && gap < 40) begin
      if (bcd !== 12'h037) stable = 0;
      @(negedge clk); gap++;
    end
    start = 1'b0;
    chk("held period", 32'(gap), 32'd10);
    chk("held bcd stable", 32'(stable), 32'd1);
    pop_check("held 184", {4'h0, bcd});
    @(negedge clk);
    chk("held done single", 32'(done), 32'd0);

    // start while busy is ignored
    @(negedge clk); start = 1'b1; din = 8'd12; sb.push_back(ref_bcd(12));
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; din = 8'd250;
    @(negedge clk); start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) pop_check("ignore", {4'h0, bcd});
      end
      @(negedge clk);
    end
    chk("ignore done count", 32'(ndone), 32'd1);
    chk("ignore queue empty", 32'(sb.size()), 32'd0);

    // reset in the middle of a conversion
    @(negedge clk); start = 1'b1; din = 8'd255;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    clr_n = 1'b0;
    #1;
    chk("midreset bcd", 32'(bcd), 32'h0);
    chk("midreset busy", 32'(busy), 32'h0);
    chk("midreset done", 32'(done), 32'h0);
    @(negedge clk); clr_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("midreset no done", 32'(ndone), 32'd0);
    run8(7, "after reset d7");

    // exhaustive sweep for N=8
    for (int v = 0; v < 256; v++) run8(v, $sformatf("sweep %0d", v));

    // wider instance
    run13(8191, "n13 8191");
    run13(0,    "n13 0");
    run13(1000, "n13 1000");
    run13(4095, "n13 4095");
    run13(5009, "n13 5009");
    for (int k = 0; k < 4; k++) run13(int'($urandom_range(0, 8191)), "n13 rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
